// File: rtl/lsq_store_arbiter.sv
// Round-robin arbiter that joins per-requester address/data tokens and feeds one LSQ store port
// through a single output slot whose address and data channels drain independently.
module lsq_store_arbiter #(
    parameter int unsigned NUM_PORTS     = 2,
    parameter int unsigned DATA_TYPE     = 32,
    parameter int unsigned ADDR_TYPE     = 32,
    parameter int unsigned PORT_ID_WIDTH = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS*DATA_TYPE-1:0] dataIn,
    input  logic [NUM_PORTS-1:0]           dataIn_valid,
    output logic [NUM_PORTS-1:0]           dataIn_ready,
    input  logic [NUM_PORTS*ADDR_TYPE-1:0] addrIn,
    input  logic [NUM_PORTS-1:0]           addrIn_valid,
    output logic [NUM_PORTS-1:0]           addrIn_ready,
    output logic [DATA_TYPE-1:0]           dataToMem,
    output logic                           dataToMem_valid,
    input  logic                           dataToMem_ready,
    output logic [ADDR_TYPE-1:0]           addrOut,
    output logic                           addrOut_valid,
    input  logic                           addrOut_ready,
    output logic [PORT_ID_WIDTH-1:0]       portId,
    output logic                           idle
);

    logic [NUM_PORTS-1:0]     w_elig;
    logic [NUM_PORTS-1:0]     w_ready;
    logic                     w_free;
    logic                     w_any;
    logic                     w_grant;
    logic [PORT_ID_WIDTH-1:0] w_idx;
    logic [ADDR_TYPE-1:0]     w_sel_addr;
    logic [DATA_TYPE-1:0]     w_sel_data;
    int unsigned              w_scan;

    logic                     r_addr_pend;
    logic                     r_data_pend;
    logic [ADDR_TYPE-1:0]     r_addr;
    logic [DATA_TYPE-1:0]     r_data;
    logic [PORT_ID_WIDTH-1:0] r_port;
    logic [PORT_ID_WIDTH-1:0] r_last;

    assign w_elig = dataIn_valid & addrIn_valid;

    // A new load may overlap the cycle in which the last pending handshake completes.
    assign w_free = (!r_addr_pend || addrOut_ready) && (!r_data_pend || dataToMem_ready);

    // Scan last+1, last+2, ... with wrap; the first eligible requester wins.
    always_comb begin
        w_any      = 1'b0;
        w_idx      = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        w_scan     = 0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            w_scan = (32'(r_last) + k) % NUM_PORTS;
            if (!w_any && w_elig[w_scan]) begin
                w_any      = 1'b1;
                w_idx      = w_scan[PORT_ID_WIDTH-1:0];
                w_sel_addr = addrIn[w_scan*ADDR_TYPE +: ADDR_TYPE];
                w_sel_data = dataIn[w_scan*DATA_TYPE +: DATA_TYPE];
            end
        end
    end

    assign w_grant = w_free && w_any && !rst;

    always_comb begin
        w_ready = '0;
        if (w_grant) begin
            w_ready[w_idx] = 1'b1;
        end
    end

    assign dataIn_ready = w_ready;
    assign addrIn_ready = w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_pend <= 1'b0;
            r_data_pend <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_port      <= '0;
            r_last      <= PORT_ID_WIDTH'(NUM_PORTS - 1);
        end else if (w_grant) begin
            r_addr_pend <= 1'b1;
            r_data_pend <= 1'b1;
            r_addr      <= w_sel_addr;
            r_data      <= w_sel_data;
            r_port      <= w_idx;
            r_last      <= w_idx;
        end else begin
            if (r_addr_pend && addrOut_ready) begin
                r_addr_pend <= 1'b0;
            end
            if (r_data_pend && dataToMem_ready) begin
                r_data_pend <= 1'b0;
            end
        end
    end

    assign addrOut         = r_addr;
    assign addrOut_valid   = r_addr_pend;
    assign dataToMem       = r_data;
    assign dataToMem_valid = r_data_pend;
    assign portId          = r_port;
    assign idle            = !r_addr_pend && !r_data_pend && !(|w_elig);

endmodule

// File: tb/tb_lsq_store_arbiter.sv
// Bench for lsq_store_arbiter: directed scenarios plus a randomized run against a slot model.
module tb_lsq_store_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int PW = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] dataIn;
    logic [N-1:0]    dataIn_valid;
    logic [N-1:0]    dataIn_ready;
    logic [N*AW-1:0] addrIn;
    logic [N-1:0]    addrIn_valid;
    logic [N-1:0]    addrIn_ready;
    logic [DW-1:0]   dataToMem;
    logic            dataToMem_valid;
    logic            dataToMem_ready;
    logic [AW-1:0]   addrOut;
    logic            addrOut_valid;
    logic            addrOut_ready;
    logic [PW-1:0]   portId;
    logic            idle;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsq_store_arbiter #(
        .NUM_PORTS    (N),
        .DATA_TYPE    (DW),
        .ADDR_TYPE    (AW),
        .PORT_ID_WIDTH(PW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dataIn         (dataIn),
        .dataIn_valid   (dataIn_valid),
        .dataIn_ready   (dataIn_ready),
        .addrIn         (addrIn),
        .addrIn_valid   (addrIn_valid),
        .addrIn_ready   (addrIn_ready),
        .dataToMem      (dataToMem),
        .dataToMem_valid(dataToMem_valid),
        .dataToMem_ready(dataToMem_ready),
        .addrOut        (addrOut),
        .addrOut_valid  (addrOut_valid),
        .addrOut_ready  (addrOut_ready),
        .portId         (portId),
        .idle           (idle)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic av, input logic dv,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        addrIn_valid[p]      = av;
        dataIn_valid[p]      = dv;
        addrIn[p*AW +: AW]   = a;
        dataIn[p*DW +: DW]   = d;
    endtask

    task automatic clear_inputs();
        addrIn_valid = '0;
        dataIn_valid = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        addrOut_ready = 1'b1;
        dataToMem_ready = 1'b1;
        set_port(0, 1'b1, 1'b1, 32'h11, 32'h22);
        set_port(1, 1'b1, 1'b1, 32'h33, 32'h44);
        tick();
        #1;
        checks++;
        if (addrIn_ready !== 2'b00 || dataIn_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_readies got a=%b d=%b want 00", addrIn_ready, dataIn_ready);
        end
        checks++;
        if (addrOut_valid !== 1'b0 || dataToMem_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids got a=%b d=%b want 0", addrOut_valid, dataToMem_valid);
        end
        checks++;
        if (addrOut !== 32'h0 || dataToMem !== 32'h0 || portId !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got addr=%h data=%h port=%0d want 0", addrOut, dataToMem,
                     portId);
        end
        rst = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle got %b want 1", idle);
        end
    endtask

    task automatic test_single();
        addrOut_ready = 1'b1;
        dataToMem_ready = 1'b1;
        set_port(1, 1'b1, 1'b1, 32'h10, 32'hAA);
        #1;
        checks++;
        if (addrIn_ready !== 2'b10 || dataIn_ready !== 2'b10) begin
            errors++;
            $display("FAIL single_ready got a=%b d=%b want 10", addrIn_ready, dataIn_ready);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (addrOut !== 32'h10 || dataToMem !== 32'hAA || portId !== 1'b1) begin
            errors++;
            $display("FAIL single_out got addr=%h data=%h port=%0d want 10 aa 1", addrOut,
                     dataToMem, portId);
        end
        checks++;
        if (addrOut_valid !== 1'b1 || dataToMem_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_valid got a=%b d=%b want 1", addrOut_valid, dataToMem_valid);
        end
        tick();
        checks++;
        if (addrOut_valid !== 1'b0 || dataToMem_valid !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL single_drain got a=%b d=%b idle=%b want 0 0 1", addrOut_valid,
                     dataToMem_valid, idle);
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_rdy;
        do_reset();
        addrOut_ready = 1'b1;
        dataToMem_ready = 1'b1;
        set_port(0, 1'b1, 1'b1, 32'h100, 32'h200);
        set_port(1, 1'b1, 1'b1, 32'h101, 32'h201);
        for (int c = 0; c < 4; c++) begin
            exp_rdy = '0;
            exp_rdy[c % 2] = 1'b1;
            #1;
            checks++;
            if (addrIn_ready !== exp_rdy || dataIn_ready !== exp_rdy) begin
                errors++;
                $display("FAIL contention_ready[%0d] got %b want %b", c, addrIn_ready, exp_rdy);
            end
            tick();
            checks++;
            if (portId !== PW'(c % 2) || addrOut !== 32'(32'h100 + c % 2)) begin
                errors++;
                $display("FAIL contention_port[%0d] got port=%0d addr=%h want %0d", c, portId,
                         addrOut, c % 2);
            end
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_split();
        addrOut_ready = 1'b1;
        dataToMem_ready = 1'b0;
        set_port(0, 1'b1, 1'b1, 32'h300, 32'h400);
        #1;
        checks++;
        if (addrIn_ready !== 2'b01) begin
            errors++;
            $display("FAIL split_first_ready got %b want 01", addrIn_ready);
        end
        tick();
        set_port(0, 1'b1, 1'b1, 32'h301, 32'h401);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (addrIn_ready !== 2'b00 || dataToMem_valid !== 1'b1 ||
                addrOut_valid !== (c == 0)) begin
                errors++;
                $display("FAIL split_hold[%0d] got rdy=%b dv=%b av=%b", c, addrIn_ready,
                         dataToMem_valid, addrOut_valid);
            end
            tick();
        end
        dataToMem_ready = 1'b1;
        #1;
        checks++;
        if (addrIn_ready !== 2'b01 || dataIn_ready !== 2'b01) begin
            errors++;
            $display("FAIL split_reload_ready got %b want 01", addrIn_ready);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (addrOut !== 32'h301 || dataToMem !== 32'h401 || addrOut_valid !== 1'b1 ||
            dataToMem_valid !== 1'b1) begin
            errors++;
            $display("FAIL split_reload_out got addr=%h data=%h want 301 401", addrOut,
                     dataToMem);
        end
        tick();
    endtask

    task automatic test_half_valid();
        do_reset();
        addrOut_ready = 1'b1;
        dataToMem_ready = 1'b1;
        set_port(0, 1'b1, 1'b0, 32'h500, 32'h600);
        set_port(1, 1'b1, 1'b1, 32'h510, 32'h610);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (addrIn_ready !== 2'b10 || dataIn_ready !== 2'b10) begin
                errors++;
                $display("FAIL half_ready[%0d] got a=%b d=%b want 10", c, addrIn_ready,
                         dataIn_ready);
            end
            tick();
            checks++;
            if (portId !== 1'b1) begin
                errors++;
                $display("FAIL half_port[%0d] got %0d want 1", c, portId);
            end
        end
        set_port(0, 1'b1, 1'b1, 32'h500, 32'h600);
        set_port(1, 1'b0, 1'b0, 32'h510, 32'h610);
        #1;
        checks++;
        if (addrIn_ready !== 2'b01) begin
            errors++;
            $display("FAIL half_join_ready got %b want 01", addrIn_ready);
        end
        tick();
        clear_inputs();
        checks++;
        if (portId !== 1'b0 || addrOut !== 32'h500) begin
            errors++;
            $display("FAIL half_join_out got port=%0d addr=%h want 0 500", portId, addrOut);
        end
        tick();
    endtask

    task automatic test_backpressure();
        addrOut_ready = 1'b0;
        dataToMem_ready = 1'b0;
        set_port(0, 1'b1, 1'b1, 32'h1, 32'h2);
        set_port(1, 1'b1, 1'b1, 32'h1234, 32'h5678);
        #1;
        checks++;
        if (addrIn_ready !== 2'b10) begin
            errors++;
            $display("FAIL bp_ready got %b want 10", addrIn_ready);
        end
        tick();
        set_port(1, 1'b1, 1'b1, 32'hDEAD, 32'hBEEF);
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (addrOut !== 32'h1234 || dataToMem !== 32'h5678 || portId !== 1'b1 ||
                addrIn_ready !== 2'b00 || addrOut_valid !== 1'b1 || dataToMem_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d] got addr=%h data=%h port=%0d rdy=%b", c, addrOut,
                         dataToMem, portId, addrIn_ready);
            end
            tick();
        end
    endtask

    task automatic test_reset_midop();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (addrOut_valid !== 1'b0 || dataToMem_valid !== 1'b0 || portId !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset got av=%b dv=%b port=%0d want 0 0 0", addrOut_valid,
                     dataToMem_valid, portId);
        end
        addrOut_ready = 1'b1;
        dataToMem_ready = 1'b1;
        #1;
        checks++;
        if (addrIn_ready !== 2'b01) begin
            errors++;
            $display("FAIL midop_first_ready got %b want 01", addrIn_ready);
        end
        tick();
        checks++;
        if (portId !== 1'b0 || addrOut !== 32'h1) begin
            errors++;
            $display("FAIL midop_first_port got port=%0d addr=%h want 0 1", portId, addrOut);
        end
        clear_inputs();
        tick();
    endtask

    // Model: the slot is a held store plus the set of LSQ channels it still owes.
    task automatic test_random();
        bit           m_owe_addr;
        bit           m_owe_data;
        int           m_last;
        int           m_port;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_data;
        logic [AW-1:0] a_in[N];
        logic [DW-1:0] d_in[N];
        bit           elig[N];
        int           order[$];
        int           win;
        bit           free;
        logic [N-1:0] exp_rdy;
        int           mism;
        do_reset();
        m_owe_addr = 0;
        m_owe_data = 0;
        m_last = N - 1;
        m_port = 0;
        m_addr = '0;
        m_data = '0;
        mism = 0;
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < N; p++) begin
                a_in[p] = $urandom;
                d_in[p] = $urandom;
                set_port(p, ($urandom % 4) != 0, ($urandom % 4) != 0, a_in[p], d_in[p]);
                elig[p] = addrIn_valid[p] && dataIn_valid[p];
            end
            addrOut_ready = ($urandom % 3) != 0;
            dataToMem_ready = ($urandom % 3) != 0;
            order = {};
            for (int k = 1; k <= N; k++) order.push_back((m_last + k) % N);
            win = -1;
            foreach (order[i]) if (win < 0 && elig[order[i]]) win = order[i];
            free = (!m_owe_addr || addrOut_ready) && (!m_owe_data || dataToMem_ready);
            exp_rdy = '0;
            if (free && win >= 0) exp_rdy[win] = 1'b1;
            #1;
            checks++;
            if (addrIn_ready !== exp_rdy || dataIn_ready !== exp_rdy ||
                addrOut_valid !== m_owe_addr || dataToMem_valid !== m_owe_data ||
                addrOut !== m_addr || dataToMem !== m_data || portId !== PW'(m_port) ||
                idle !== (!m_owe_addr && !m_owe_data && win < 0)) begin
                errors++;
                mism++;
                if (mism <= 10)
                    $display("FAIL random[%0d] got rdy=%b av=%b dv=%b addr=%h data=%h port=%0d idle=%b want rdy=%b av=%b dv=%b addr=%h data=%h port=%0d",
                             c, addrIn_ready, addrOut_valid, dataToMem_valid, addrOut, dataToMem,
                             portId, idle, exp_rdy, m_owe_addr, m_owe_data, m_addr, m_data,
                             m_port);
            end
            if (free && win >= 0) begin
                m_owe_addr = 1;
                m_owe_data = 1;
                m_addr = a_in[win];
                m_data = d_in[win];
                m_port = win;
                m_last = win;
            end else begin
                if (addrOut_ready) m_owe_addr = 0;
                if (dataToMem_ready) m_owe_data = 0;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        dataIn = '0;
        addrIn = '0;
        dataIn_valid = '0;
        addrIn_valid = '0;
        dataToMem_ready = 1'b0;
        addrOut_ready = 1'b0;
        #2;
        test_reset();
        test_single();
        test_contention();
        test_split();
        test_half_valid();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
